// File: rtl/uart_rx_deser.sv
// uart_rx_deser -- oversampling UART receiver / deserialiser.
//
// Consumes the serial line from the UART transmitter. Each bit period is
// OVERSAMPLE Tick pulses long. A falling edge in IDLE starts a frame. The
// start bit is confirmed at mid-bit. NBits data bits (5..8) are then taken
// LSB first, followed by an optional parity bit and then the stop bit, each
// sampled once per bit period. The word is presented with a one-cycle
// RxDone strobe.
//
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and the
// ParOdd input; when undefined ParErr is tied low).
//
// Ports:
//   Clk      in   system clock, posedge
//   Rst_n    in   asynchronous active-low reset
//   Tick     in   baud oversample enable, one Clk wide
//   Rx       in   serial line, idle high, asynchronous to Clk
//   NBits    in   data bits per frame (clamped to 5..8, latched at start)
//   ParOdd   in   odd(1)/even(0) parity select (UART_RX_PARITY_EN only)
//   RxData   out  received word, right-aligned, upper bits zero
//   RxDone   out  one-cycle strobe, coincides with a Tick cycle
//   FrameErr out  stop bit sampled low
//   ParErr   out  parity mismatch
//   Busy     out  receiver not in IDLE
module uart_rx_deser #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       Rx,
    input  logic [3:0] NBits,
`ifdef UART_RX_PARITY_EN
    input  logic       ParOdd,
`endif
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       ParErr,
    output logic       Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [3:0]             nbits_q, nbits_d;
    logic [7:0]             shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   done_pend_q, done_pend_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_s;
    logic [7:0]             mask_s;
    logic [7:0]             data_masked_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_odd_q, par_odd_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_q, par_err_d;
`endif

    // Input synchroniser; flops reset high so reset looks like an idle line.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
        end
    end

    assign rxs_s         = sync_q[SYNC_STAGES-1];
    // nbits_q is 5..8 once latched, so the shift is 0..3.
    assign mask_s        = 8'hFF >> (4'd8 - nbits_q);
    assign data_masked_s = shift_q & mask_s;

    // Next-state and datapath update; everything steps only on Tick cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        nbits_d     = nbits_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        frame_err_d = frame_err_q;
        // The pending strobe is shown on the next Tick cycle, then drops.
        done_pend_d = done_pend_q & ~Tick;
`ifdef UART_RX_PARITY_EN
        par_odd_d   = par_odd_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
`endif

        // A high line in IDLE re-arms start detection (blocks stuck-low restarts).
        if ((state_q == S_IDLE) && rxs_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_d;
        end

        if (Tick) begin
            cnt_d = cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    if (!rxs_s && armed_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rxs_s) begin
                            if (NBits < 4'd5) begin
                                nbits_d = 4'd5;
                            end else if (NBits > 4'd8) begin
                                nbits_d = 4'd8;
                            end else begin
                                nbits_d = NBits;
                            end
`ifdef UART_RX_PARITY_EN
                            par_odd_d = ParOdd;
`endif
                            cnt_d   = '0;
                            idx_d   = 3'd0;
                            shift_d = 8'h00;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_END) begin
                        shift_d[idx_q] = rxs_s;
                        idx_d          = idx_q + 3'd1;
                        if ({1'b0, idx_q} == (nbits_q - 4'd1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_END) begin
`ifdef UART_RX_PARITY_EN
                        par_bit_d = rxs_s;
`endif
                        state_d = S_STOP;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_END) begin
                        rx_data_d   = data_masked_s;
                        frame_err_d = ~rxs_s;
`ifdef UART_RX_PARITY_EN
                        par_err_d   = ((^data_masked_s) ^ par_bit_q) != par_odd_q;
`endif
                        done_pend_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            nbits_q     <= 4'd0;
            shift_q     <= 8'h00;
            armed_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            done_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_odd_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            nbits_q     <= nbits_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            done_pend_q <= done_pend_d;
`ifdef UART_RX_PARITY_EN
            par_odd_q   <= par_odd_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign RxData   = rx_data_q;
    assign FrameErr = frame_err_q;
    assign RxDone   = done_pend_q & Tick;
    assign Busy     = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign ParErr   = par_err_q;
`else
    assign ParErr   = 1'b0;
`endif

endmodule
